aes_uart_ctrl: RTL and testbench

Byte-stream controller between the UART receiver/transmitter and the `aes256_enc` core. It collects a 256-bit key and 128-bit plaintext blocks from received bytes using a two-command framing protocol. It pulses the core's `start`, waits for `ready`, and then serializes the 128-bit ciphertext back out through the UART transmitter, MSB byte first.

---
 rtl/aes_uart_if.sv | 25 ++
 rtl/aes_uart_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_aes_uart_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_uart_if.sv
// Signal bundle between aes_uart_ctrl and its UART receiver/transmitter and aes256_enc core.
interface aes_uart_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic [255:0] key_out;
  logic [127:0] blk_out;
  logic         enc_start;
  logic         enc_ready;
  logic [127:0] enc_data;
  logic         busy;
  logic         overrun;

  modport master (
    input  rx_data, rx_valid, tx_busy, enc_ready, enc_data,
    output tx_data, tx_start, key_out, blk_out, enc_start, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, enc_ready, enc_data,
    input  tx_data, tx_start, key_out, blk_out, enc_start, busy, overrun
  );
endinterface

// File: rtl/aes_uart_ctrl.sv
// Frames UART bytes into a 256-bit key and 128-bit blocks for aes256_enc,
// then streams the ciphertext back out through the UART transmitter, MSB byte first.
module aes_uart_ctrl #(
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_DATA       = 8'h44,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  aes_uart_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_KEY   = 3'd1,
    S_RX_DATA  = 3'd2,
    S_START    = 3'd3,
    S_WAIT_ENC = 3'd4,
    S_TX_SEND  = 3'd5,
    S_TX_GAP   = 3'd6
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  state_t         r_state;
  state_t         w_next;
  logic [4:0]     r_byte_cnt;
  logic [4:0]     r_tx_cnt;
  logic [31:0]    r_idle_cnt;
  logic [247:0]   r_stage;
  logic [255:0]   r_key;
  logic [127:0]   r_blk;
  logic [127:0]   r_tx_shift;
  logic [7:0]     r_tx_last;
  logic           r_rdy_prev;
  logic           w_timeout;
  logic           w_rdy_edge;
  logic           w_tx_fire;
  logic           w_overrun;

  assign w_timeout  = TO_EN && (r_idle_cnt == TO_LAST);
  assign w_rdy_edge = bus.enc_ready && !r_rdy_prev;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the strobes that must respond in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_tx_fire = 1'b0;
    w_overrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == CMD_KEY)) begin
          w_next = S_RX_KEY;
        end else if (bus.rx_valid && (bus.rx_data == CMD_DATA)) begin
          w_next = S_RX_DATA;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RX_KEY: begin
        if (bus.rx_valid) begin
          w_next = (r_byte_cnt == 5'd31) ? S_IDLE : S_RX_KEY;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RX_KEY;
        end
      end
      S_RX_DATA: begin
        if (bus.rx_valid) begin
          w_next = (r_byte_cnt == 5'd15) ? S_START : S_RX_DATA;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RX_DATA;
        end
      end
      S_START: begin
        w_overrun = bus.rx_valid;
        w_next    = S_WAIT_ENC;
      end
      S_WAIT_ENC: begin
        w_overrun = bus.rx_valid;
        if (w_rdy_edge) begin
          w_next = S_TX_SEND;
        end else begin
          w_next = S_WAIT_ENC;
        end
      end
      S_TX_SEND: begin
        w_overrun = bus.rx_valid;
        if (!bus.tx_busy) begin
          w_tx_fire = 1'b1;
          w_next    = S_TX_GAP;
        end else begin
          w_next = S_TX_SEND;
        end
      end
      S_TX_GAP: begin
        w_overrun = bus.rx_valid;
        w_next    = (r_tx_cnt < 5'd16) ? S_TX_SEND : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Frame assembly, idle timer, completion edge history and transmit shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt <= 5'd0;
      r_tx_cnt   <= 5'd0;
      r_idle_cnt <= 32'd0;
      r_stage    <= 248'd0;
      r_key      <= 256'd0;
      r_blk      <= 128'd0;
      r_tx_shift <= 128'd0;
      r_tx_last  <= 8'd0;
      r_rdy_prev <= 1'b0;
    end else begin
      // Forcing the history high in START masks a ready left high by the previous block.
      r_rdy_prev <= (r_state == S_START) ? 1'b1 : bus.enc_ready;
      case (r_state)
        S_IDLE: begin
          r_byte_cnt <= 5'd0;
          r_idle_cnt <= 32'd0;
          if (w_next == S_RX_KEY) begin
            r_stage <= 248'd0;
          end
        end
        S_RX_KEY: begin
          if (bus.rx_valid) begin
            r_stage    <= {r_stage[239:0], bus.rx_data};
            r_byte_cnt <= r_byte_cnt + 5'd1;
            r_idle_cnt <= 32'd0;
            if (r_byte_cnt == 5'd31) begin
              r_key <= {r_stage, bus.rx_data};
            end
          end else if (w_timeout) begin
            r_stage    <= 248'd0;
            r_idle_cnt <= 32'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
          end
        end
        S_RX_DATA: begin
          if (bus.rx_valid) begin
            r_blk      <= {r_blk[119:0], bus.rx_data};
            r_byte_cnt <= r_byte_cnt + 5'd1;
            r_idle_cnt <= 32'd0;
          end else if (w_timeout) begin
            r_idle_cnt <= 32'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
          end
        end
        S_WAIT_ENC: begin
          if (w_rdy_edge) begin
            r_tx_shift <= bus.enc_data;
            r_tx_cnt   <= 5'd0;
          end
        end
        S_TX_SEND: begin
          if (w_tx_fire) begin
            r_tx_last  <= r_tx_shift[127:120];
            r_tx_shift <= {r_tx_shift[119:0], 8'h00};
            r_tx_cnt   <= r_tx_cnt + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // tx_data shows the new byte in the start cycle, then holds it while the UART is busy.
  assign bus.tx_data   = w_tx_fire ? r_tx_shift[127:120] : r_tx_last;
  assign bus.tx_start  = w_tx_fire;
  assign bus.overrun   = w_overrun;
  assign bus.enc_start = (r_state == S_START);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.key_out   = r_key;
  assign bus.blk_out   = r_blk;

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Scoreboard bench for aes_uart_ctrl with a behavioural UART transmitter and AES core.
module tb_aes_uart_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aes_uart_if ifc ();

  aes_uart_ctrl #(
    .CMD_KEY(8'h4B),
    .CMD_DATA(8'h44),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B     = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT_C     = 128'hdeadbeefcafef00d0badc0de13579bdf;

  int n_pass = 0;
  int n_total = 0;
  int n_start = 0;
  int n_ovr = 0;
  int n_tx = 0;
  int tx_gap_len = 3;
  int tx_cnt = 0;
  int core_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_tx = 8'h00;
  bit have_last = 1'b0;
  logic [255:0] model_key = 256'd0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Stand-in core: real FIPS answer for the FIPS vector, a simple mix otherwise.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k[255:128] ^ k[127:0] ^ {p[63:0], p[127:64]};
  endfunction

  // Core model: ready drops after start and rises 12 cycles later with the result.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cnt <= 0;
      ifc.enc_ready <= 1'b1;
      ifc.enc_data <= 128'd0;
    end else if (ifc.enc_start) begin
      core_cnt <= 12;
      ifc.enc_ready <= 1'b0;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      ifc.enc_ready <= 1'b1;
      ifc.enc_data <= core_fn(ifc.key_out, ifc.blk_out);
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  // UART transmitter model: busy for tx_gap_len cycles after each start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt <= 0;
      ifc.tx_busy <= 1'b0;
    end else if (ifc.tx_start) begin
      tx_cnt <= tx_gap_len;
      ifc.tx_busy <= 1'b1;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_cnt <= 0;
      ifc.tx_busy <= 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every transmitted byte and counts strobes.
  always @(negedge clk) begin
    if (!reset_n) begin
      have_last <= 1'b0;
    end else begin
      if (ifc.enc_start) n_start <= n_start + 1;
      if (ifc.overrun) n_ovr <= n_ovr + 1;
      if (ifc.tx_start) begin
        chk("tx_start_while_busy", 256'(ifc.tx_busy), 256'd0);
        if (exp_q.size() == 0) begin
          n_total = n_total + 1;
          $display("FAIL unexpected_tx_start: got byte %h, required no tx_start", ifc.tx_data);
        end else begin
          chk("tx_byte", 256'(ifc.tx_data), 256'(exp_q.pop_front()));
        end
        last_tx <= ifc.tx_data;
        have_last <= 1'b1;
        n_tx <= n_tx + 1;
      end else if (have_last && ifc.tx_busy) begin
        chk("tx_data_stable", 256'(ifc.tx_data), 256'(last_tx));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.rx_data = b;
    ifc.rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] k);
    send_byte(8'h4B);
    for (int i = 0; i < 32; i++) send_byte(k[255-8*i -: 8]);
    chk("key_commit", ifc.key_out, k);
    chk("key_idle", 256'(ifc.busy), 256'd0);
    model_key = k;
  endtask

  task automatic send_data(input logic [127:0] p);
    logic [127:0] ct;
    ct = core_fn(model_key, p);
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
    send_byte(8'h44);
    for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8]);
    chk("enc_start_timing", 256'(ifc.enc_start), 256'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ifc.busy) break;
    end
    chk({name, "_drained"}, 256'(exp_q.size()), 256'd0);
    chk({name, "_idle"}, 256'(ifc.busy), 256'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int o0;
    int t0;
    logic [255:0] k0;
    ifc.rx_data = 8'h00;
    ifc.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key", ifc.key_out, 256'd0);
    chk("rst_blk", 256'(ifc.blk_out), 256'd0);
    chk("rst_busy", 256'(ifc.busy), 256'd0);
    chk("rst_tx_start", 256'(ifc.tx_start), 256'd0);
    chk("rst_tx_data", 256'(ifc.tx_data), 256'd0);
    chk("rst_enc_start", 256'(ifc.enc_start), 256'd0);
    reset_n = 1'b1;

    // Non-command bytes in IDLE are ignored silently.
    send_byte(8'h55);
    chk("ignore_busy", 256'(ifc.busy), 256'd0);
    chk("ignore_overrun", 256'(n_ovr), 256'd0);

    // FIPS-197 C.3.
    load_key(FIPS_KEY);
    s0 = n_start;
    t0 = n_tx;
    send_data(FIPS_PT);
    wait_idle("fips");
    chk("fips_starts", 256'(n_start - s0), 256'd1);
    chk("fips_tx_count", 256'(n_tx - t0), 256'd16);

    // Back-to-back identical blocks.
    s0 = n_start;
    send_data(FIPS_PT);
    wait_idle("b2b_1");
    send_data(FIPS_PT);
    wait_idle("b2b_2");
    chk("b2b_starts", 256'(n_start - s0), 256'd2);

    // Bytes dropped while waiting on the core.
    o0 = n_ovr;
    send_data(PT_B);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      ifc.rx_data = 8'hEE;
      ifc.rx_valid = 1'b1;
      @(posedge clk); #1;
      ifc.rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    wait_idle("drop");
    chk("drop_overruns", 256'(n_ovr - o0), 256'd3);
    chk("drop_blk", 256'(ifc.blk_out), 256'(PT_B));
    send_data(FIPS_PT);
    wait_idle("after_drop");

    // Partial key frame times out and leaves the key alone.
    k0 = model_key;
    send_byte(8'h4B);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    repeat (50) @(negedge clk);
    chk("timeout_pending_busy", 256'(ifc.busy), 256'd1);
    repeat (60) @(negedge clk);
    chk("timeout_idle", 256'(ifc.busy), 256'd0);
    chk("timeout_key", ifc.key_out, k0);
    send_data(PT_B);
    wait_idle("timeout_next");

    // Slow transmitter.
    tx_gap_len = 50;
    t0 = n_tx;
    send_data(PT_C);
    wait_idle("backpressure");
    chk("backpressure_tx_count", 256'(n_tx - t0), 256'd16);
    tx_gap_len = 3;

    // Reset in the middle of the ciphertext.
    t0 = n_tx;
    send_data(PT_C);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_tx >= t0 + 5) break;
    end
    chk("reset_reached_5", 256'(n_tx - t0), 256'd5);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", 256'(ifc.tx_start), 256'd0);
    chk("mid_rst_tx_data", 256'(ifc.tx_data), 256'd0);
    chk("mid_rst_busy", 256'(ifc.busy), 256'd0);
    chk("mid_rst_enc_start", 256'(ifc.enc_start), 256'd0);
    chk("mid_rst_overrun", 256'(ifc.overrun), 256'd0);
    chk("mid_rst_key", ifc.key_out, 256'd0);
    chk("mid_rst_blk", 256'(ifc.blk_out), 256'd0);
    exp_q.delete();
    model_key = 256'd0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    t0 = n_tx;
    repeat (40) @(negedge clk);
    chk("no_tx_after_reset", 256'(n_tx - t0), 256'd0);
    send_data(PT_B);
    wait_idle("post_reset_zero_key");
    load_key(FIPS_KEY);
    send_data(FIPS_PT);
    wait_idle("post_reset_fips");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
